// File: rtl/wavefront_threshold_calc.sv
// Finds the largest valid per-lane offset with a pipelined max tree (one level per
// cycle), then turns it into a clamped pruning threshold: base - max_offset + margin.
module wavefront_threshold_calc #(
    parameter int MAX_WAVEFRONT_LEN = 128,
    parameter int LOG_MAX_TILE_SIZE = 10,
    parameter int DATA_WIDTH        = 8,
    parameter int REF_LEN_WIDTH     = 14,
    parameter int QUERY_LEN_WIDTH   = 14
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic [DATA_WIDTH-1:0]                                 numDiag,
    input  logic [MAX_WAVEFRONT_LEN-1:0][LOG_MAX_TILE_SIZE-1:0]   OffsetReg,
    input  logic [MAX_WAVEFRONT_LEN-1:0]                          valid_M,
    input  logic [QUERY_LEN_WIDTH-1:0]                            queryLen,
    input  logic [REF_LEN_WIDTH-1:0]                              refLen,
    input  logic                                                  len_sel,
    input  logic [7:0]                                            margin,
    output logic [REF_LEN_WIDTH-1:0]                              threshold,
    output logic [LOG_MAX_TILE_SIZE-1:0]                          max_offset,
    output logic [$clog2(MAX_WAVEFRONT_LEN)-1:0]                  max_idx,
    output logic                                                  any_valid,
    output logic                                                  busy,
    output logic                                                  done
);

    localparam int N  = MAX_WAVEFRONT_LEN;
    localparam int L  = $clog2(MAX_WAVEFRONT_LEN);
    localparam int T  = LOG_MAX_TILE_SIZE;
    localparam int R  = REF_LEN_WIDTH;
    localparam int SW = $clog2(L + 1);
    localparam int S  = ((QUERY_LEN_WIDTH > REF_LEN_WIDTH) ? QUERY_LEN_WIDTH : REF_LEN_WIDTH) + 2;

    typedef enum logic [1:0] {IDLE, REDUCE, FINAL} state_t;

    typedef struct packed {
        logic         valid;
        logic [L-1:0] idx;
        logic [T:0]   val;   // two's complement, -1 marks an inactive lane
    } node_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    node_t           tree_q [N];
    node_t           tree_d [N];

    logic [QUERY_LEN_WIDTH-1:0] qlen_q;
    logic [R-1:0]               rlen_q;
    logic                       len_sel_q;
    logic [7:0]                 margin_q;

    logic [R-1:0]    threshold_q, threshold_d;
    logic [T-1:0]    max_offset_q, max_offset_d;
    logic [L-1:0]    max_idx_q, max_idx_d;
    logic            any_valid_q, any_valid_d;
    logic            done_q, done_d;

    logic [DATA_WIDTH:0] nd_plus1;
    logic [S-1:0]        base_ext;
    logic [S-1:0]        sum;
    logic [R-1:0]        clamped;

    assign nd_plus1 = {1'b0, numDiag} + (DATA_WIDTH+1)'(1);

    // Leaf load on accept, otherwise one pairwise-max level per REDUCE cycle.
    // The result migrates toward index 0; slots above the live width are don't-care.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        tree_d = tree_q;
        if (state_q == IDLE && start) begin
            for (int j = 0; j < N; j++) begin
                if (valid_M[j] && (j <= int'(nd_plus1))) begin
                    tree_d[j].valid = 1'b1;
                    tree_d[j].val   = {1'b0, OffsetReg[j]};
                end else begin
                    tree_d[j].valid = 1'b0;
                    tree_d[j].val   = '1;
                end
                tree_d[j].idx = L'(j);
            end
        end else if (state_q == REDUCE) begin
            for (int i = 0; i < N / 2; i++) begin
                tree_d[i] = ($signed(tree_q[2*i+1].val) > $signed(tree_q[2*i].val))
                            ? tree_q[2*i+1] : tree_q[2*i];
                tree_d[i].valid = tree_q[2*i].valid | tree_q[2*i+1].valid;
            end
        end
    end

    // Width-extended arithmetic; the top bit is the sign of the true result.
    always_comb begin
        base_ext = len_sel_q ? S'(rlen_q) : S'(qlen_q);
        sum      = base_ext - S'(tree_q[0].val[T-1:0]) + S'(margin_q);
        if (sum[S-1])
            clamped = '0;
        else if (|sum[S-2:R])
            clamped = '1;
        else
            clamped = sum[R-1:0];
    end

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        done_d       = 1'b0;
        threshold_d  = threshold_q;
        max_offset_d = max_offset_q;
        max_idx_d    = max_idx_q;
        any_valid_d  = any_valid_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REDUCE;
                    stage_d = '0;
                end
            end
            REDUCE: begin
                stage_d = stage_q + SW'(1);
                if (stage_q == SW'(L - 1))
                    state_d = FINAL;
            end
            FINAL: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (tree_q[0].valid) begin
                    any_valid_d  = 1'b1;
                    threshold_d  = clamped;
                    max_offset_d = tree_q[0].val[T-1:0];
                    max_idx_d    = tree_q[0].idx;
                end else begin
                    any_valid_d  = 1'b0;
                    threshold_d  = '1;
                    max_offset_d = '0;
                    max_idx_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            stage_q      <= '0;
            done_q       <= 1'b0;
            threshold_q  <= '0;
            max_offset_q <= '0;
            max_idx_q    <= '0;
            any_valid_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            stage_q      <= stage_d;
            done_q       <= done_d;
            threshold_q  <= threshold_d;
            max_offset_q <= max_offset_d;
            max_idx_q    <= max_idx_d;
            any_valid_q  <= any_valid_d;
        end
    end

    // NOTE: the tree and captured operands are fully rewritten on every accept, so they carry no reset.
    always_ff @(posedge clk) begin
        tree_q <= tree_d;
        if (state_q == IDLE && start) begin
            qlen_q    <= queryLen;
            rlen_q    <= refLen;
            len_sel_q <= len_sel;
            margin_q  <= margin;
        end
    end

    assign threshold  = threshold_q;
    assign max_offset = max_offset_q;
    assign max_idx    = max_idx_q;
    assign any_valid  = any_valid_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

endmodule
